// File: rtl/regfile_scoreboard.sv
// Parametrised register file with post-reset clearing sweep, pending-write scoreboard and debug port.
// Optional write-first forwarding on the read ports is enabled by defining RF_BYPASS_EN.
module regfile_scoreboard #(
    parameter int                DATA_W  = 32,
    parameter int                ADDR_W  = 5,
    parameter int                NUM_RD  = 2,
    parameter int                SP_IDX  = 2,
    parameter logic [DATA_W-1:0] SP_INIT = 32'h7fffefe4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       we,
    input  logic [ADDR_W-1:0]          waddr,
    input  logic [DATA_W-1:0]          wdata,
    input  logic [NUM_RD*ADDR_W-1:0]   raddr,
    output logic [NUM_RD*DATA_W-1:0]   rdata,
    output logic [NUM_RD-1:0]          rd_busy,
    input  logic                       issue_valid,
    input  logic [ADDR_W-1:0]          issue_rd,
    input  logic [ADDR_W-1:0]          dbg_sel,
    output logic [DATA_W-1:0]          dbg_data,
    output logic                       init_done
);
    localparam int                DEPTH   = 2**ADDR_W;
    localparam logic [ADDR_W-1:0] SP_ADDR = ADDR_W'(SP_IDX);
    localparam logic [ADDR_W-1:0] LAST    = {ADDR_W{1'b1}};
    localparam logic [0:0]        S_INIT  = 1'b0;
    localparam logic [0:0]        S_READY = 1'b1;

    logic [0:0]        state;
    logic [ADDR_W-1:0] cnt;
    logic [DATA_W-1:0] mem [DEPTH];
    logic [DEPTH-1:0]  busy, busy_nxt;

    assign init_done = (state == S_READY);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= S_INIT;
            cnt   <= '0;
        end else if (state == S_INIT) begin
            cnt <= cnt + 1'b1;
            if (cnt == LAST) state <= S_READY;
        end
    end

    // Array has no reset; the sweep is the only thing that defines its contents.
    always_ff @(posedge clk) begin
        if (state == S_INIT)
            mem[cnt] <= (cnt == SP_ADDR) ? SP_INIT : '0;
        else if (we && waddr != '0)
            mem[waddr] <= wdata;
    end

    // Clear first, then set, so an issue on the retiring index keeps it pending.
    always_comb begin
        busy_nxt = busy;
        if (init_done) begin
            if (we)                              busy_nxt[waddr]    = 1'b0;
            if (issue_valid && issue_rd != '0)   busy_nxt[issue_rd] = 1'b1;
        end
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) busy <= '0;
        else        busy <= busy_nxt;
    end

    for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
        logic [ADDR_W-1:0] ra;
        logic [DATA_W-1:0] stored;
        logic              hit;
        assign ra     = raddr[i*ADDR_W +: ADDR_W];
        assign stored = (ra == '0) ? '0 : mem[ra];
`ifdef RF_BYPASS_EN
        assign hit    = we && init_done && (waddr != '0) && (waddr == ra);
`else
        assign hit    = 1'b0;
`endif
        assign rdata[i*DATA_W +: DATA_W] = !init_done ? '0 : (hit ? wdata : stored);
        assign rd_busy[i]                = init_done && !hit && busy[ra];
    end

    assign dbg_data = (init_done && dbg_sel != '0) ? mem[dbg_sel] : '0;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Randomized + directed bench for regfile_scoreboard (NUM_RD=3) against a behavioural model.
// Builds with or without RF_BYPASS_EN; the model follows the same define.
module tb_regfile_scoreboard;
    localparam int NR = 3;
`ifdef RF_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif
    localparam logic [31:0] SP_VAL = 32'h7fffefe4;

    logic          clk = 1'b0;
    logic          rst_n, we, issue_valid;
    logic [4:0]    waddr, issue_rd, dbg_sel;
    logic [31:0]   wdata, dbg_data;
    logic [NR*5-1:0]  raddr;
    logic [NR*32-1:0] rdata;
    logic [NR-1:0] rd_busy;
    logic          init_done;

    regfile_scoreboard #(.DATA_W(32), .ADDR_W(5), .NUM_RD(NR), .SP_IDX(2), .SP_INIT(SP_VAL)) dut (
        .clk(clk), .rst_n(rst_n), .we(we), .waddr(waddr), .wdata(wdata),
        .raddr(raddr), .rdata(rdata), .rd_busy(rd_busy),
        .issue_valid(issue_valid), .issue_rd(issue_rd),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data), .init_done(init_done)
    );

    always #5 clk = ~clk;

    int checks = 0, failures = 0;

    // model state
    logic [31:0] m_mem [32];
    bit          m_busy [32];
    bit          m_ready;
    int          m_sweep;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [NR*32-1:0] er;
        logic [NR-1:0]    eb;
        logic [31:0]      ed;
        logic [4:0]       ra;
        bit               byp;
        er = '0; eb = '0; ed = '0;
        if (m_ready) begin
            for (int i = 0; i < NR; i++) begin
                ra  = raddr[i*5 +: 5];
                byp = BYP && we && (waddr != 0) && (waddr == ra);
                er[i*32 +: 32] = byp ? wdata : ((ra == 0) ? 32'h0 : m_mem[ra]);
                eb[i]          = byp ? 1'b0 : m_busy[ra];
            end
            ed = (dbg_sel == 0) ? 32'h0 : m_mem[dbg_sel];
        end
        chk("init_done", 128'(init_done), 128'(m_ready));
        chk("rdata",     128'(rdata),     128'(er));
        chk("rd_busy",   128'(rd_busy),   128'(eb));
        chk("dbg_data",  128'(dbg_data),  128'(ed));
    endtask

    task automatic model_edge();
        if (!rst_n) return;
        if (!m_ready) begin
            m_sweep++;
            if (m_sweep == 32) begin
                m_ready = 1'b1;
                for (int j = 0; j < 32; j++) m_mem[j] = (j == 2) ? SP_VAL : 32'h0;
            end
            return;
        end
        if (we) m_busy[waddr] = 1'b0;
        if (issue_valid && issue_rd != 0) m_busy[issue_rd] = 1'b1;
        if (we && waddr != 0) m_mem[waddr] = wdata;
    endtask

    task automatic cycle();
        #1 check_outputs();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic idle_inputs();
        we = 0; waddr = 0; wdata = 0; issue_valid = 0; issue_rd = 0; dbg_sel = 0; raddr = '0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        #1;
        m_ready = 1'b0; m_sweep = 0;
        for (int j = 0; j < 32; j++) m_busy[j] = 1'b0;
        check_outputs();
    endtask

    task automatic release_and_sweep(input string tag);
        int n;
        n = 0;
        rst_n = 1'b1;
        while (n < 100) begin
            cycle();
            n++;
            if (init_done) break;
        end
        chk(tag, 128'(n), 128'd32);
    endtask

    function automatic logic [4:0] rnd_addr();
        return ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
    endfunction

    initial begin
        idle_inputs();
        for (int j = 0; j < 32; j++) begin m_mem[j] = 32'h0; m_busy[j] = 1'b0; end
        m_ready = 1'b0; m_sweep = 0;
        rst_n = 1'b1;
        #2 do_reset();
        repeat (3) cycle();

        // sweep with a write/issue attempted mid-way; both must be dropped
        rst_n = 1'b1;
        repeat (4) cycle();
        we = 1; waddr = 5; wdata = 32'hDEADBEEF; raddr[4:0] = 5;
        issue_valid = 1; issue_rd = 5;
        cycle();
        idle_inputs();
        begin
            int n;
            n = 5;
            while (n < 100 && !init_done) begin cycle(); n++; end
            chk("sweep_len", 128'(n), 128'd32);
        end
        for (int j = 0; j < 32; j += NR) begin
            for (int i = 0; i < NR; i++) raddr[i*5 +: 5] = 5'((j + i) % 32);
            dbg_sel = 5'(j);
            cycle();
        end

        // write to index 0 is dropped; issue to 0 never marks busy
        idle_inputs();
        we = 1; waddr = 0; wdata = 32'h12345678; issue_valid = 1; issue_rd = 0;
        cycle();
        idle_inputs();
        cycle();
        chk("r0_zero", 128'(rdata[31:0]), 128'h0);
        chk("r0_busy", 128'(rd_busy[0]), 128'h0);

        // write/read collision on index 9
        we = 1; waddr = 9; wdata = 32'hA5A5A5A5; raddr[4:0] = 9;
        #1 chk("collide9", 128'(rdata[31:0]), BYP ? 128'hA5A5A5A5 : 128'h0);
        cycle();
        we = 0;
        cycle();
        chk("after9", 128'(rdata[31:0]), 128'hA5A5A5A5);

        // issue 7, then issue 7 again while its write retires: stays busy
        idle_inputs();
        raddr[4:0] = 7;
        issue_valid = 1; issue_rd = 7;
        cycle();
        we = 1; waddr = 7; wdata = 32'h77;
        cycle();
        idle_inputs(); raddr[4:0] = 7;
        cycle();
        chk("busy7_kept", 128'(rd_busy[0]), 128'h1);
        we = 1; waddr = 7; wdata = 32'h78;
        cycle();
        idle_inputs(); raddr[4:0] = 7;
        cycle();
        chk("busy7_clr", 128'(rd_busy[0]), 128'h0);

        // all ports on index 28
        we = 1; waddr = 28; wdata = 32'h1;
        cycle();
        idle_inputs();
        for (int i = 0; i < NR; i++) raddr[i*5 +: 5] = 28;
        dbg_sel = 28;
        cycle();
        chk("multi28", 128'(rdata), 128'({32'h1, 32'h1, 32'h1}));
        chk("dbg28", 128'(dbg_data), 128'h1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            we = 1'($urandom_range(0, 1)); waddr = rnd_addr(); wdata = $urandom();
            issue_valid = 1'($urandom_range(0, 1)); issue_rd = rnd_addr();
            for (int i = 0; i < NR; i++) raddr[i*5 +: 5] = rnd_addr();
            dbg_sel = rnd_addr();
            cycle();
        end

        // reset mid-READY with busy[5] pending
        idle_inputs();
        issue_valid = 1; issue_rd = 5;
        cycle();
        idle_inputs(); raddr[4:0] = 5;
        cycle();
        chk("busy5_set", 128'(rd_busy[0]), 128'h1);
        do_reset();
        chk("rst_done", 128'(init_done), 128'h0);
        cycle();
        release_and_sweep("sweep_after_ready_rst");
        raddr[4:0] = 5;
        cycle();
        chk("busy5_gone", 128'(rd_busy[0]), 128'h0);

        // reset at sweep index 10
        do_reset();
        cycle();
        rst_n = 1'b1;
        repeat (10) cycle();
        do_reset();
        chk("rst_mid_sweep", 128'(init_done), 128'h0);
        cycle();
        release_and_sweep("sweep_after_mid_rst");
        for (int i = 0; i < NR; i++) raddr[i*5 +: 5] = 5'(i + 1);
        dbg_sel = 2;
        cycle();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
